iq_acq_sequencer: RTL

IQ_ACQ_SEQUENCER -- requirements
Module: iq_acq_sequencer

---
 rtl/iq_acq_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/iq_acq_sequencer.sv
// IQ acquisition sequencer: start delay, decimated capture of an even word count into a
// downstream FIFO, a fixed drain flush and a one-cycle done pulse.
module iq_acq_sequencer #(
  parameter int unsigned DEC_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned DLY_WIDTH = 16,
  parameter int unsigned DRAIN_CYC = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [DEC_WIDTH-1:0] cfg_dec_fact,
  input  logic [DLY_WIDTH-1:0] cfg_delay,
  input  logic [CNT_WIDTH-1:0] cfg_num_words,
  output logic [DEC_WIDTH-1:0] dec_fact_out,
  output logic                 dec_in_valid,
  input  logic                 dec_out_valid,
  input  logic                 fifo_full,
  output logic                 fifo_wr,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic                 aborted,
  output logic                 cfg_err,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  localparam int unsigned DrnW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {StIdle, StDelay, StAcq, StDrain, StDone} state_e;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] num_words_q;
  logic [DLY_WIDTH-1:0] dly_cnt_q;
  logic [DrnW-1:0]      drn_cnt_q;

  logic xfer;
  logic cnt_open;
  logic last_word;
  logic cfg_ok;

  assign xfer      = (state_q == StAcq) || (state_q == StDrain);
  assign cnt_open  = word_cnt < num_words_q;
  assign fifo_wr   = xfer && dec_out_valid && !fifo_full && cnt_open;
  assign last_word = fifo_wr && (word_cnt == num_words_q - 1'b1);
  // I and Q words come in pairs, so the count must be even and non-zero
  assign cfg_ok    = (cfg_dec_fact >= DEC_WIDTH'(3)) && (cfg_num_words != '0) &&
                     !cfg_num_words[0];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= StIdle;
      num_words_q  <= '0;
      dly_cnt_q    <= '0;
      drn_cnt_q    <= '0;
      dec_fact_out <= '0;
      dec_in_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      aborted      <= 1'b0;
      cfg_err      <= 1'b0;
      word_cnt     <= '0;
    end else begin
      done <= 1'b0;
      if (fifo_wr) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (xfer && dec_out_valid && fifo_full && cnt_open) begin
        overflow <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (START && !ABORT) begin
            if (cfg_ok) begin
              dec_fact_out <= cfg_dec_fact;
              num_words_q  <= cfg_num_words;
              dly_cnt_q    <= cfg_delay;
              word_cnt     <= '0;
              overflow     <= 1'b0;
              aborted      <= 1'b0;
              cfg_err      <= 1'b0;
              busy         <= 1'b1;
              if (cfg_delay == '0) begin
                state_q      <= StAcq;
                dec_in_valid <= 1'b1;
              end else begin
                state_q <= StDelay;
              end
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        StDelay: begin
          if (ABORT) begin
            state_q   <= StDrain;
            aborted   <= 1'b1;
            drn_cnt_q <= DrnW'(DRAIN_CYC - 1);
          end else if (dly_cnt_q == DLY_WIDTH'(1)) begin
            state_q      <= StAcq;
            dec_in_valid <= 1'b1;
          end else begin
            dly_cnt_q <= dly_cnt_q - 1'b1;
          end
        end
        StAcq: begin
          // A final word coinciding with ABORT is still written above
          if (ABORT || last_word) begin
            state_q      <= StDrain;
            dec_in_valid <= 1'b0;
            drn_cnt_q    <= DrnW'(DRAIN_CYC - 1);
            if (ABORT) begin
              aborted <= 1'b1;
            end
          end
        end
        StDrain: begin
          if (drn_cnt_q == '0) begin
            state_q <= StDone;
            done    <= 1'b1;
          end else begin
            drn_cnt_q <= drn_cnt_q - 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
